// File: rtl/qtcore_pin_bridge.sv
// Pad-side bridge for the qtcore: synchronises chip-selects and the button, arbitrates
// scan/processor access with a small FSM, debounces the button and drives the pad LEDs.
module qtcore_pin_bridge #(
  parameter int LED_W           = 7,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scan_csn,
  input  logic             proc_csn,
  input  logic             sdi,
  input  logic             btn_raw,
  output logic             miso,
  output logic [LED_W-1:0] led_pad,
  output logic             fault,
  output logic [CNT_W-1:0] scan_bits,
  output logic             scan_enable,
  output logic             scan_in,
  input  logic             scan_out,
  output logic             proc_en,
  input  logic             halt,
  output logic             btn_out,
  input  logic [LED_W-1:0] led_in
);

  typedef enum logic [1:0] {IDLE, SCAN, PROC, FAULT} state_t;

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] scan_sync;
  logic [SYNC_STAGES-1:0] proc_sync;
  logic [SYNC_STAGES-1:0] btn_sync;
  logic                   scs;
  logic                   pcs;
  logic                   bs;
  state_t                 state;
  state_t                 state_next;
  logic                   enter_scan;
  logic                   halt_latched;
  logic [DB_W-1:0]        db_cnt;
  logic [LED_W-1:0]       led_q;

  // Chip-selects idle high so a reset never looks like a fresh select.
  always_ff @(posedge clk) begin
    if (!rst) begin
      scan_sync <= '1;
      proc_sync <= '1;
      btn_sync  <= '0;
    end else begin
      scan_sync <= {scan_sync[SYNC_STAGES-2:0], scan_csn};
      proc_sync <= {proc_sync[SYNC_STAGES-2:0], proc_csn};
      btn_sync  <= {btn_sync[SYNC_STAGES-2:0], btn_raw};
    end
  end

  assign scs = scan_sync[SYNC_STAGES-1];
  assign pcs = proc_sync[SYNC_STAGES-1];
  assign bs  = btn_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (!scs && !pcs)     state_next = FAULT;
        else if (!scs && pcs) state_next = SCAN;
        else if (!pcs && scs) state_next = PROC;
      end
      SCAN:  if (scs) state_next = IDLE;
      PROC:  if (pcs) state_next = IDLE;
      FAULT: if (scs && pcs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    scan_enable = 1'b0;
    scan_in     = 1'b0;
    proc_en     = 1'b0;
    miso        = 1'b0;
    fault       = 1'b0;
    led_pad     = led_q;
    unique case (state)
      SCAN: begin
        scan_enable = 1'b1;
        scan_in     = sdi;
        miso        = scan_out;
      end
      PROC: begin
        proc_en = !halt_latched;
        miso    = halt_latched;
      end
      FAULT: begin
        fault   = 1'b1;
        led_pad = '1;
      end
      default: ;
    endcase
  end

  assign enter_scan = (state == IDLE) && (state_next == SCAN);

  // A halt stays latched across PROC sessions until a scan session starts.
  always_ff @(posedge clk) begin
    if (!rst)                         halt_latched <= 1'b0;
    else if (enter_scan)              halt_latched <= 1'b0;
    else if (state == PROC && halt)   halt_latched <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst)                                 scan_bits <= '0;
    else if (enter_scan)                      scan_bits <= '0;
    else if (state == SCAN && scan_bits != '1) scan_bits <= scan_bits + CNT_W'(1);
  end

  // The toggle fires on the cycle the count would reach DEBOUNCE_CYCLES.
  always_ff @(posedge clk) begin
    if (!rst) begin
      db_cnt  <= '0;
      btn_out <= 1'b0;
    end else if (bs == btn_out) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      btn_out <= bs;
      db_cnt  <= '0;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) led_q <= '0;
    else      led_q <= led_in;
  end

endmodule

// File: tb/tb_qtcore_pin_bridge.sv
// Self-checking bench for qtcore_pin_bridge: table-driven FSM vectors through a
// scoreboard queue, plus hand sequences for scan counting, debouncing and reset.
module tb_qtcore_pin_bridge;

  logic       clk = 1'b0;
  logic       rst;
  logic       scan_csn, proc_csn, sdi, btn_raw, scan_out, halt;
  logic [6:0] led_in;
  logic       miso, fault, scan_enable, scan_in, proc_en, btn_out;
  logic [6:0] led_pad;
  logic [7:0] scan_bits;

  logic       s_miso, s_fault, s_scan_enable, s_scan_in, s_proc_en, s_btn_out;
  logic [6:0] s_led_pad;
  logic [2:0] s_scan_bits;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  qtcore_pin_bridge dut (
    .clk(clk), .rst(rst), .scan_csn(scan_csn), .proc_csn(proc_csn), .sdi(sdi),
    .btn_raw(btn_raw), .miso(miso), .led_pad(led_pad), .fault(fault),
    .scan_bits(scan_bits), .scan_enable(scan_enable), .scan_in(scan_in),
    .scan_out(scan_out), .proc_en(proc_en), .halt(halt), .btn_out(btn_out),
    .led_in(led_in)
  );

  qtcore_pin_bridge #(.CNT_W(3)) dut_small (
    .clk(clk), .rst(rst), .scan_csn(scan_csn), .proc_csn(proc_csn), .sdi(sdi),
    .btn_raw(btn_raw), .miso(s_miso), .led_pad(s_led_pad), .fault(s_fault),
    .scan_bits(s_scan_bits), .scan_enable(s_scan_enable), .scan_in(s_scan_in),
    .scan_out(scan_out), .proc_en(s_proc_en), .halt(halt), .btn_out(s_btn_out),
    .led_in(led_in)
  );

  typedef struct {
    string      name;
    logic       scn, pcn, sdi, so, halt;
    logic [6:0] led;
    int         cyc;
    logic       se, pe, si, miso, fault;
    logic [6:0] ledp;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  function automatic vec_t mk(string name, logic scn, logic pcn, logic sd, logic so,
                              logic hl, logic [6:0] led, int cyc, logic se, logic pe,
                              logic si, logic mi, logic fl, logic [6:0] ledp);
    vec_t v;
    v.name = name; v.scn = scn; v.pcn = pcn; v.sdi = sd; v.so = so; v.halt = hl;
    v.led = led; v.cyc = cyc; v.se = se; v.pe = pe; v.si = si; v.miso = mi;
    v.fault = fl; v.ledp = ledp;
    return v;
  endfunction

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkValue(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(vec_t v);
    scan_csn = v.scn; proc_csn = v.pcn; sdi = v.sdi; scan_out = v.so;
    halt = v.halt; led_in = v.led;
    tick(v.cyc);
    exp_q.push_back(v);
  endtask

  task automatic checkOutput();
    vec_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard: got empty queue expected entry");
      return;
    end
    e = exp_q.pop_front();
    checkValue({e.name, ".scan_enable"}, 32'(scan_enable), 32'(e.se));
    checkValue({e.name, ".proc_en"},     32'(proc_en),     32'(e.pe));
    checkValue({e.name, ".scan_in"},     32'(scan_in),     32'(e.si));
    checkValue({e.name, ".miso"},        32'(miso),        32'(e.miso));
    checkValue({e.name, ".fault"},       32'(fault),       32'(e.fault));
    checkValue({e.name, ".led_pad"},     32'(led_pad),     32'(e.ledp));
  endtask

  initial begin
    // name, scn pcn sdi so halt led cyc | se pe si miso fault ledp
    tbl.push_back(mk("idle",           1, 1, 1, 1, 0, 7'h2A, 1, 0, 0, 0, 0, 0, 7'h2A));
    tbl.push_back(mk("scan_lat2",      0, 1, 1, 1, 0, 7'h2A, 2, 0, 0, 0, 0, 0, 7'h2A));
    tbl.push_back(mk("scan_lat3",      0, 1, 1, 1, 0, 7'h2A, 1, 1, 0, 1, 1, 0, 7'h2A));
    tbl.push_back(mk("scan_sdi0",      0, 1, 0, 0, 0, 7'h2A, 1, 1, 0, 0, 0, 0, 7'h2A));
    tbl.push_back(mk("scan_pcs_low",   0, 0, 1, 1, 0, 7'h2A, 4, 1, 0, 1, 1, 0, 7'h2A));
    tbl.push_back(mk("scan_miso0",     0, 0, 1, 0, 0, 7'h2A, 1, 1, 0, 1, 0, 0, 7'h2A));
    tbl.push_back(mk("scan_exit",      1, 0, 1, 1, 0, 7'h2A, 3, 0, 0, 0, 0, 0, 7'h2A));
    tbl.push_back(mk("proc_enter",     1, 0, 1, 1, 0, 7'h2A, 1, 0, 1, 0, 0, 0, 7'h2A));
    tbl.push_back(mk("proc_halt",      1, 0, 1, 1, 1, 7'h2A, 1, 0, 0, 0, 1, 0, 7'h2A));
    tbl.push_back(mk("proc_halt_hold", 1, 0, 1, 1, 0, 7'h2A, 2, 0, 0, 0, 1, 0, 7'h2A));
    tbl.push_back(mk("proc_exit",      1, 1, 1, 1, 0, 7'h2A, 3, 0, 0, 0, 0, 0, 7'h2A));
    tbl.push_back(mk("proc_reenter",   1, 0, 1, 1, 0, 7'h2A, 3, 0, 0, 0, 1, 0, 7'h2A));
    tbl.push_back(mk("proc_scs_ign",   0, 0, 1, 1, 0, 7'h2A, 3, 0, 0, 0, 1, 0, 7'h2A));
    tbl.push_back(mk("proc_to_idle",   0, 1, 1, 1, 0, 7'h2A, 3, 0, 0, 0, 0, 0, 7'h2A));
    tbl.push_back(mk("rescan",         0, 1, 1, 1, 0, 7'h2A, 1, 1, 0, 1, 1, 0, 7'h2A));
    tbl.push_back(mk("rescan_exit",    1, 1, 1, 1, 0, 7'h2A, 3, 0, 0, 0, 0, 0, 7'h2A));
    tbl.push_back(mk("proc_cleared",   1, 0, 1, 1, 0, 7'h2A, 3, 0, 1, 0, 0, 0, 7'h2A));
    tbl.push_back(mk("proc_exit2",     1, 1, 1, 1, 0, 7'h2A, 3, 0, 0, 0, 0, 0, 7'h2A));
    tbl.push_back(mk("fault_enter",    0, 0, 1, 1, 0, 7'h2A, 3, 0, 0, 0, 0, 1, 7'h7F));
    tbl.push_back(mk("fault_scs_rel",  1, 0, 1, 1, 0, 7'h2A, 4, 0, 0, 0, 0, 1, 7'h7F));
    tbl.push_back(mk("fault_pcs_rel",  0, 1, 1, 1, 0, 7'h2A, 4, 0, 0, 0, 0, 1, 7'h7F));
    tbl.push_back(mk("fault_release",  1, 1, 1, 1, 0, 7'h55, 3, 0, 0, 0, 0, 0, 7'h55));
    tbl.push_back(mk("idle_led",       1, 1, 1, 1, 0, 7'h0F, 1, 0, 0, 0, 0, 0, 7'h0F));

    rst = 1'b0; scan_csn = 1'b1; proc_csn = 1'b1; sdi = 1'b1; btn_raw = 1'b0;
    scan_out = 1'b1; halt = 1'b0; led_in = 7'h2A;
    tick(2);
    checkValue("rst.scan_enable", 32'(scan_enable), 32'd0);
    checkValue("rst.proc_en",     32'(proc_en),     32'd0);
    checkValue("rst.scan_in",     32'(scan_in),     32'd0);
    checkValue("rst.miso",        32'(miso),        32'd0);
    checkValue("rst.fault",       32'(fault),       32'd0);
    checkValue("rst.led_pad",     32'(led_pad),     32'd0);
    checkValue("rst.btn_out",     32'(btn_out),     32'd0);
    checkValue("rst.scan_bits",   32'(scan_bits),   32'd0);
    rst = 1'b1;

    foreach (tbl[i]) begin
      applyStimulus(tbl[i]);
      checkOutput();
    end

    // Scan session: count, saturation in the 3-bit instance, hold after exit.
    scan_csn = 1'b0; proc_csn = 1'b1;
    tick(3);
    checkValue("sb.start",       32'(scan_bits),   32'd0);
    checkValue("sb.start_small", 32'(s_scan_bits), 32'd0);
    tick(10);
    checkValue("sb.ten",         32'(scan_bits),   32'd10);
    tick(10);
    checkValue("sb.twenty",      32'(scan_bits),   32'd20);
    checkValue("sb.sat_small",   32'(s_scan_bits), 32'd7);
    scan_csn = 1'b1;
    tick(5);
    checkValue("sb.hold",        32'(scan_bits),   32'd23);
    checkValue("sb.hold_se",     32'(scan_enable), 32'd0);
    checkValue("sb.hold_small",  32'(s_scan_bits), 32'd7);

    // Debounce: a 3-cycle pulse is rejected, a held press lands 4 cycles after bs.
    btn_raw = 1'b1;
    tick(3);
    btn_raw = 1'b0;
    tick(8);
    checkValue("db.pulse", 32'(btn_out), 32'd0);
    btn_raw = 1'b1;
    tick(5);
    checkValue("db.early", 32'(btn_out), 32'd0);
    tick(1);
    checkValue("db.rise",  32'(btn_out), 32'd1);

    // Reset in PROC with a latched halt clears everything, including the latch.
    proc_csn = 1'b0;
    tick(3);
    checkValue("pr.enter", 32'(proc_en), 32'd1);
    halt = 1'b1;
    tick(1);
    halt = 1'b0;
    checkValue("pr.halt_pe",   32'(proc_en), 32'd0);
    checkValue("pr.halt_miso", 32'(miso),    32'd1);
    led_in = 7'h33;
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    checkValue("pr.rst_pe",      32'(proc_en),     32'd0);
    checkValue("pr.rst_miso",    32'(miso),        32'd0);
    checkValue("pr.rst_se",      32'(scan_enable), 32'd0);
    checkValue("pr.rst_fault",   32'(fault),       32'd0);
    checkValue("pr.rst_led",     32'(led_pad),     32'd0);
    checkValue("pr.rst_btn",     32'(btn_out),     32'd0);
    checkValue("pr.rst_bits",    32'(scan_bits),   32'd0);
    tick(2);
    checkValue("pr.relat",       32'(proc_en),     32'd0);
    tick(1);
    checkValue("pr.reenter_pe",  32'(proc_en),     32'd1);
    checkValue("pr.reenter_miso",32'(miso),        32'd0);
    checkValue("pr.led",         32'(led_pad),     32'h33);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
